// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: picks one eligible thread per cycle (RR / fixed priority / greedy-then-RR)
// with per-thread starvation aging, and offers it over a valid/ready issue handshake.
module warp_issue_scheduler #(
  parameter int NUM_THREADS = 8,
  parameter int TID_W       = 3,
  parameter int AGE_W       = 4,
  parameter int MAX_GREEDY  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [NUM_THREADS-1:0] active_threads,
  input  logic [NUM_THREADS-1:0] stalled_threads,
  input  logic                   issue_ready,
  output logic                   issue_valid,
  output logic [TID_W-1:0]       issue_thread,
  output logic                   starve_alert
);

  localparam int                GC_W     = $clog2(MAX_GREEDY + 1);
  localparam logic [AGE_W-1:0]  AGE_MAX  = {AGE_W{1'b1}};
  localparam logic [TID_W-1:0]  LAST_RST = TID_W'(NUM_THREADS - 1);
  localparam logic [GC_W-1:0]   GC_MAX   = GC_W'(MAX_GREEDY);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t                 state_r, state_s;
  logic [TID_W-1:0]       thread_r, thread_s;
  logic [TID_W-1:0]       last_r, last_s;
  logic [GC_W-1:0]        gcnt_r, gcnt_s;
  logic [AGE_W-1:0]       age_r [NUM_THREADS];
  logic [AGE_W-1:0]       age_s [NUM_THREADS];
  logic                   starve_r, starve_s;
  logic [NUM_THREADS-1:0] eligible_s, issued_s, sat_s;
  logic                   handshake_s;
  logic                   rr_found_s, prio_found_s, sel_found_s;
  logic [TID_W-1:0]       rr_tid_s, prio_tid_s, sat_tid_s, sel_tid_s;

  assign eligible_s  = active_threads & ~stalled_threads;
  assign handshake_s = (state_r == OFFER) && issue_ready;

  // Issue bookkeeping: issued one-hot, saturated-age masks, and the handshake update of last/greedy count.
  always_comb begin
    issued_s = '0;
    sat_s    = '0;
    starve_s = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      issued_s[i] = handshake_s && (thread_r == TID_W'(i));
      // A thread issued at this edge has its age cleared, so it must not win the override again.
      sat_s[i]    = eligible_s[i] && (age_r[i] == AGE_MAX) && !issued_s[i];
      starve_s    = starve_s | (eligible_s[i] && (age_r[i] == AGE_MAX));
    end
    if (handshake_s) begin
      last_s = thread_r;
      if (thread_r == last_r) begin
        gcnt_s = (gcnt_r == GC_MAX) ? GC_MAX : gcnt_r + GC_W'(1);
      end else begin
        gcnt_s = GC_W'(1);
      end
    end else begin
      last_s = last_r;
      gcnt_s = gcnt_r;
    end
  end

  // Candidate pickers: RR after last_s, lowest-index eligible, lowest-index saturated.
  always_comb begin
    rr_found_s   = 1'b0;
    rr_tid_s     = '0;
    prio_found_s = 1'b0;
    prio_tid_s   = '0;
    sat_tid_s    = '0;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      if (eligible_s[(int'(last_s) + k) % NUM_THREADS]) begin
        rr_found_s = 1'b1;
        rr_tid_s   = TID_W'((int'(last_s) + k) % NUM_THREADS);
      end else begin
        rr_tid_s   = rr_tid_s;
      end
    end
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (eligible_s[i]) begin
        prio_found_s = 1'b1;
        prio_tid_s   = TID_W'(i);
      end else begin
        prio_tid_s   = prio_tid_s;
      end
      if (sat_s[i]) begin
        sat_tid_s = TID_W'(i);
      end else begin
        sat_tid_s = sat_tid_s;
      end
    end
  end

  // Policy selection; the starvation override beats every mode.
  always_comb begin
    sel_found_s = 1'b0;
    sel_tid_s   = '0;
    if (|sat_s) begin
      sel_found_s = 1'b1;
      sel_tid_s   = sat_tid_s;
    end else begin
      case (mode)
        2'd1: begin
          sel_found_s = prio_found_s;
          sel_tid_s   = prio_tid_s;
        end
        2'd2: begin
          if ((int'(last_s) < NUM_THREADS) && eligible_s[int'(last_s)] && (gcnt_s < GC_MAX)) begin
            sel_found_s = 1'b1;
            sel_tid_s   = last_s;
          end else begin
            sel_found_s = rr_found_s;
            sel_tid_s   = rr_tid_s;
          end
        end
        default: begin
          sel_found_s = rr_found_s;
          sel_tid_s   = rr_tid_s;
        end
      endcase
    end
  end

  // Offer FSM next state: an offer is held untouched until the handshake.
  always_comb begin
    state_s  = state_r;
    thread_s = thread_r;
    case (state_r)
      IDLE: begin
        if (sel_found_s) begin
          state_s  = OFFER;
          thread_s = sel_tid_s;
        end else begin
          state_s  = IDLE;
        end
      end
      OFFER: begin
        if (issue_ready && sel_found_s) begin
          state_s  = OFFER;
          thread_s = sel_tid_s;
        end else if (issue_ready) begin
          state_s  = IDLE;
        end else begin
          state_s  = OFFER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Per-thread aging: clear on issue or inactivity, count while eligible, hold while stalled.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      age_s[i] = age_r[i];
      if (!active_threads[i] || issued_s[i]) begin
        age_s[i] = '0;
      end else if (eligible_s[i] && (age_r[i] != AGE_MAX)) begin
        age_s[i] = age_r[i] + AGE_W'(1);
      end else begin
        age_s[i] = age_r[i];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      thread_r <= '0;
      last_r   <= LAST_RST;
      gcnt_r   <= '0;
      starve_r <= 1'b0;
      for (int i = 0; i < NUM_THREADS; i++) age_r[i] <= '0;
    end else begin
      state_r  <= state_s;
      thread_r <= thread_s;
      last_r   <= last_s;
      gcnt_r   <= gcnt_s;
      starve_r <= starve_s;
      for (int i = 0; i < NUM_THREADS; i++) age_r[i] <= age_s[i];
    end
  end

  assign issue_valid  = (state_r == OFFER);
  assign issue_thread = thread_r;
  assign starve_alert = starve_r;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Self-checking bench for warp_issue_scheduler: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the scheduling rules.
module tb_warp_issue_scheduler;
  localparam int N = 8, AW = 4, MG = 4, AMAX = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [7:0] active_threads, stalled_threads;
  logic       issue_ready;
  logic       issue_valid;
  logic [2:0] issue_thread;
  logic       starve_alert;

  warp_issue_scheduler #(.NUM_THREADS(N), .TID_W(3), .AGE_W(AW), .MAX_GREEDY(MG)) dut (
    .clk(clk), .reset(reset), .mode(mode), .active_threads(active_threads),
    .stalled_threads(stalled_threads), .issue_ready(issue_ready), .issue_valid(issue_valid),
    .issue_thread(issue_thread), .starve_alert(starve_alert)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_valid, m_alert;
  int m_thread, m_last, m_cnt;
  int m_age [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int choose(input bit [7:0] elig, input int last, input int cnt,
                                input int md, input int excl);
    for (int i = 0; i < N; i++)
      if (elig[i] && m_age[i] == AMAX && i != excl) return i;
    if (md == 1) begin
      for (int i = 0; i < N; i++) if (elig[i]) return i;
      return -1;
    end
    if (md == 2 && elig[last] && cnt < MG) return last;
    for (int k = 1; k <= N; k++)
      if (elig[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    bit [7:0] elig;
    bit hs, alert;
    int issued, pick;
    if (reset) begin
      m_valid = 0; m_thread = 0; m_alert = 0; m_last = N - 1; m_cnt = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
      return;
    end
    elig  = active_threads & ~stalled_threads;
    hs    = m_valid && issue_ready;
    alert = 0;
    for (int i = 0; i < N; i++) if (elig[i] && m_age[i] == AMAX) alert = 1;
    issued = -1;
    if (hs) begin
      issued = m_thread;
      m_cnt  = (m_thread == m_last) ? ((m_cnt + 1 > MG) ? MG : m_cnt + 1) : 1;
      m_last = m_thread;
    end
    if (!m_valid || hs) begin
      pick    = choose(elig, m_last, m_cnt, int'(mode), issued);
      m_valid = (pick >= 0);
      if (pick >= 0) m_thread = pick;
    end
    for (int i = 0; i < N; i++) begin
      if (!active_threads[i] || i == issued) m_age[i] = 0;
      else if (elig[i]) m_age[i] = (m_age[i] == AMAX) ? AMAX : m_age[i] + 1;
    end
    m_alert = alert;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("valid", {31'd0, issue_valid}, {31'd0, m_valid});
    if (m_valid) check("thread", {29'd0, issue_thread}, m_thread);
    check("alert", {31'd0, starve_alert}, {31'd0, m_alert});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int exp_seq [];
    bit found, saw5, saw7, saw_alert;
    reset = 1'b1; mode = 2'd0; active_threads = 8'hFF; stalled_threads = 8'h00; issue_ready = 1'b1;

    // RR from reset: 0..7,0 one per cycle
    do_reset();
    check("rst_valid", {31'd0, issue_valid}, 32'd0);
    check("rst_thread", {29'd0, issue_thread}, 32'd0);
    check("rst_alert", {31'd0, starve_alert}, 32'd0);
    cycle();
    for (int j = 0; j < 9; j++) begin
      check("rr_seq", {29'd0, issue_thread}, j % 8);
      cycle();
    end

    // Backpressure on thread 3 while its stall bit toggles
    found = 0;
    for (int g = 0; g < 20 && !found; g++) begin
      if (issue_valid && issue_thread == 3'd3) found = 1;
      else cycle();
    end
    check("reach3", {31'd0, found}, 32'd1);
    issue_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      stalled_threads = (j % 2 == 0) ? 8'h08 : 8'h00;
      cycle();
      check("bp_hold", {28'd0, issue_valid, issue_thread}, 32'h0B);
    end
    stalled_threads = 8'h00; issue_ready = 1'b1;
    cycle();
    check("bp_next", {29'd0, issue_thread}, 32'd4);

    // RR skipping stalled threads, then single-thread wrap
    do_reset();
    stalled_threads = 8'h0A;
    cycle();
    exp_seq = '{0, 2, 4, 5, 6, 7, 0};
    foreach (exp_seq[j]) begin
      check("rr_stall_seq", {29'd0, issue_thread}, exp_seq[j]);
      cycle();
    end
    stalled_threads = 8'hFE;
    cycle();
    for (int j = 0; j < 4; j++) begin
      check("wrap0", {28'd0, issue_valid, issue_thread}, 32'h08);
      cycle();
    end

    // Greedy-then-RR
    stalled_threads = 8'h00; active_threads = 8'h0F; mode = 2'd2;
    do_reset();
    cycle();
    exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
    foreach (exp_seq[j]) begin
      check("greedy_seq", {29'd0, issue_thread}, exp_seq[j]);
      cycle();
    end

    // Priority mode with starvation override forcing threads 5 then 7
    active_threads = 8'hA4; mode = 2'd1;
    do_reset();
    saw5 = 0; saw7 = 0; saw_alert = 0;
    for (int j = 0; j < 40; j++) begin
      cycle();
      if (issue_valid && issue_thread == 3'd5) saw5 = 1;
      if (issue_valid && issue_thread == 3'd7 && saw5) saw7 = 1;
      if (starve_alert) saw_alert = 1;
    end
    check("starve5", {31'd0, saw5}, 32'd1);
    check("starve7", {31'd0, saw7}, 32'd1);
    check("starve_alert_seen", {31'd0, saw_alert}, 32'd1);
    check("prio_resume", {29'd0, issue_thread}, 32'd2);

    // Reset during an offer of thread 6
    active_threads = 8'hFF; mode = 2'd0;
    do_reset();
    found = 0;
    for (int g = 0; g < 20 && !found; g++) begin
      cycle();
      if (issue_valid && issue_thread == 3'd6) found = 1;
    end
    check("reach6", {31'd0, found}, 32'd1);
    issue_ready = 1'b0;
    do_reset();
    check("mid_rst_valid", {31'd0, issue_valid}, 32'd0);
    issue_ready = 1'b1;
    cycle();
    check("post_rst_first", {28'd0, issue_valid, issue_thread}, 32'h08);

    // Randomized traffic
    for (int j = 0; j < 600; j++) begin
      reset           = ($urandom_range(0, 99) == 0);
      mode            = 2'($urandom_range(0, 3));
      active_threads  = 8'($urandom) | 8'($urandom);
      stalled_threads = 8'($urandom) & 8'($urandom);
      issue_ready     = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
Parametrised successor to the single-mode round-robin thread scheduler. It selects one eligible thread per cycle (active and not stalled) and offers it downstream over a valid/ready issue handshake. Three run-time selectable policies are supported: round-robin, fixed priority and greedy-then-round-robin. A per-thread aging mechanism prevents starvation. It sits between the thread-status and scoreboard logic and the fetch/issue stage.

Parameters:
NUM_THREADS, `NUM_THREADS, number of hardware threads (>=2)
TID_W, `THREAD_ID_WIDTH, thread-ID width; must satisfy 2**TID_W >= NUM_THREADS
AGE_W, 4, width of each per-thread starvation counter
MAX_GREEDY, 4, maximum consecutive issues of one thread in greedy mode (>=1)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
mode  input  2  0 = round-robin, 1 = fixed priority (lowest index wins), 2 = greedy-then-RR, 3 = treated as 0
active_threads  input  NUM_THREADS  thread is live
stalled_threads  input  NUM_THREADS  thread is blocked by scoreboard/memory
issue_ready  input  1  downstream accepts the offer this cycle
issue_valid  output  1  an offer is presented
issue_thread  output  TID_W  ID of the offered thread
starve_alert  output  1  registered; at least one eligible thread's age counter is saturated

Behaviour:
- eligible = active_threads & ~stalled_threads, evaluated combinationally each cycle.
- Reset values, applied at the clock edge where reset=1:
  - issue_valid=0, issue_thread=0, starve_alert=0
  - last_thread=NUM_THREADS-1, so the first round-robin pick is thread 0
  - greedy_cnt=0; all age counters=0
- Two-state FSM:
  - IDLE (issue_valid=0): if eligible!=0, register the selection; go to OFFER. issue_valid rises the cycle after eligibility is seen (latency 1).
  - OFFER (issue_valid=1): issue_thread and issue_valid are held stable while issue_ready=0, even if the offered thread becomes stalled or inactive. Offers are never retracted.
  - OFFER with issue_ready=1 is a handshake ("issue"). Update last_thread and greedy_cnt. In the same edge, compute the next selection from current eligible, using the just-issued thread as last_thread. If a thread is found, stay in OFFER with the new thread; else go to IDLE.
  - Throughput: 1 issue per cycle while issue_ready is held high.
- Selection, with mode sampled in the cycle the selection is computed:
  - RR: first eligible in (last_thread+1 .. last_thread+NUM_THREADS) mod NUM_THREADS.
  - Priority: lowest-index eligible thread.
  - Greedy: if last_thread is eligible and greedy_cnt < MAX_GREEDY, reselect last_thread; otherwise apply RR.
  - greedy_cnt: on issue of the same thread as last_thread, greedy_cnt+1 (saturating); on issue of a different thread, greedy_cnt=1.
- Starvation override, which takes precedence over every mode:
  - If any eligible thread has age == 2**AGE_W-1, select the lowest-index such thread.
  - The override still only changes selection at IDLE→OFFER or at a handshake, never mid-offer.
- Age counters, per thread, each cycle:
  - Cleared if the thread is issued this cycle or active_threads[i]=0.
  - Otherwise incremented if the thread is eligible and not issued, saturating at 2**AGE_W-1.
  - Otherwise (active but stalled) held.
- starve_alert is registered: it is high in the cycle after any eligible thread's age is saturated.
- Mode change while in OFFER: the held offer is unaffected; the new mode applies to the next selection. greedy_cnt is not cleared.
- Reset asserted mid-offer: issue_valid=0 at the next edge and all state returns to reset values. The next issue after reset is thread 0 under RR.
- Single-thread wrap: in RR with only one eligible thread, that thread is reissued back-to-back every cycle.

Test Plan:
- NUM_THREADS=8, mode=0, active=0xFF, stalled=0, issue_ready=1 after reset → issue_valid rises 1 cycle after reset release; issue_thread sequence 0,1,2,3,4,5,6,7,0, one per cycle.
- Backpressure: mode=0, offer of thread 3 with issue_ready=0 for 5 cycles while stalled toggles 0x08/0x00 → issue_thread stays 3 and valid stays 1. Raise ready → 3 issues; the next offer is 4.
- mode=0, active=0xFF, stalled=0x0A, ready=1 → sequence 0,2,4,5,6,7,0. Set stalled=0xFE → thread 0 is reissued every cycle.
- mode=2, MAX_GREEDY=4, active=0x0F, ready=1 → sequence 0,0,0,0,1,1,1,1,2,2,2,2,3.
- mode=1, AGE_W=4, active=0xA4, ready=1 → thread 2 issues repeatedly. Thread 5 is force-issued once its age reaches 15, then thread 7 on the next issue. starve_alert pulses high meanwhile, then thread 2 resumes.
- Synchronous reset for 1 cycle during an OFFER of thread 6 → issue_valid=0 at the next edge. After release with active=0xFF and mode=0, the first issue_thread is 0.
